grid_io_bank_cfg: RTL and testbench

Parametrised IO bank tile for the FPGA grid edge: NUM_IO identical pad channels fed by a single configuration shift chain.
- Adds a shadow/commit stage, so shifting never disturbs live pad configuration.
- Adds a bit counter and load-state FSM that detect a complete load and flag a premature commit.
- Adds per-channel direction and polarity-invert modes, gated by the global isolation control.
- Sits on any grid side, between the SoC pad ring (gfpga_pad_io_soc_*) and the routing fabric (pin_inpad/pin_outpad).

---
 rtl/grid_io_pkg.sv | 17 +
 rtl/grid_io_cell.sv | 20 ++
 rtl/grid_io_bank_cfg.sv | 91 +++++++++
 tb/tb_grid_io_bank_cfg.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_io_pkg.sv
// rtl/grid_io_pkg.sv - shared constants and types for the grid IO bank
package grid_io_pkg;

  localparam int CFG_BITS_PER_IO = 2;
  localparam int CFG_DIR         = 0;
  localparam int CFG_INV         = 1;

  // Safe power-up mode: pad is an input, no inversion.
  localparam logic [CFG_BITS_PER_IO-1:0] CFG_RESET_IO = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL
  } load_state_t;

endpackage

// File: rtl/grid_io_cell.sv
// rtl/grid_io_cell.sv - one pad channel: direction, output and fabric-input logic
// Ports: isol_n (active-low isolation), dir/inv (live config bits),
//        soc_in/pin_outpad (data in), soc_dir/soc_out/pin_inpad (data out).
module grid_io_cell (
  input  logic isol_n,
  input  logic dir,
  input  logic inv,
  input  logic soc_in,
  input  logic pin_outpad,
  output logic soc_dir,
  output logic soc_out,
  output logic pin_inpad
);

  // Isolation forces the pad to input and silences both data directions.
  assign soc_dir   = dir | ~isol_n;
  assign soc_out   = isol_n & ~dir & (pin_outpad ^ inv);
  assign pin_inpad = isol_n & dir & (soc_in ^ inv);

endmodule

// File: rtl/grid_io_bank_cfg.sv
// rtl/grid_io_bank_cfg.sv - IO bank tile with shadow config chain and commit FSM
// Ports: prog_clk/prog_reset (clock, sync active-high reset),
//        ccff_head/ccff_en/ccff_tail (config shift chain),
//        cfg_commit (load live config), isol_n (isolation),
//        gfpga_pad_io_soc_* (SoC pad ring), pin_inpad/pin_outpad (fabric),
//        cfg_valid/cfg_err (load status).
module grid_io_bank_cfg
  import grid_io_pkg::*;
#(
  parameter int NUM_IO = 4
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              ccff_head,
  input  logic              ccff_en,
  input  logic              cfg_commit,
  input  logic              isol_n,
  input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
  input  logic [NUM_IO-1:0] pin_outpad,
  output logic              ccff_tail,
  output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir,
  output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
  output logic [NUM_IO-1:0] pin_inpad,
  output logic              cfg_valid,
  output logic              cfg_err
);

  localparam int TOTAL_BITS = NUM_IO * CFG_BITS_PER_IO;
  localparam int CNT_W      = $clog2(TOTAL_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [TOTAL_BITS-1:0] chain;
  logic [TOTAL_BITS-1:0] cfg_q;
  logic [CNT_W-1:0]      cnt;
  load_state_t           state;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      chain     <= '0;
      cfg_q     <= {NUM_IO{CFG_RESET_IO}};
      cnt       <= '0;
      state     <= IDLE;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      if (ccff_en) begin
        chain <= {chain[TOTAL_BITS-2:0], ccff_head};
      end

      // Commit outcome is decided by the pre-edge state and chain contents.
      if (cfg_commit) begin
        if (state == FULL) begin
          cfg_q     <= chain;
          cfg_valid <= 1'b1;
        end else if (state == SHIFT) begin
          cfg_err <= 1'b1;
        end
      end

      // A commit restarts the load; a shift on the same edge counts as bit one.
      if (cfg_commit) begin
        cnt   <= ccff_en ? CNT_ONE : '0;
        state <= ccff_en ? SHIFT : IDLE;
      end else if (ccff_en) begin
        if (cnt != CNT_FULL) begin
          cnt <= cnt + 1'b1;
        end
        state <= (cnt >= CNT_LAST) ? FULL : SHIFT;
      end
    end
  end

  assign ccff_tail = chain[TOTAL_BITS-1];

  for (genvar i = 0; i < NUM_IO; i++) begin : g_io
    grid_io_cell u_cell (
      .isol_n     (isol_n),
      .dir        (cfg_q[CFG_BITS_PER_IO*i + CFG_DIR]),
      .inv        (cfg_q[CFG_BITS_PER_IO*i + CFG_INV]),
      .soc_in     (gfpga_pad_io_soc_in[i]),
      .pin_outpad (pin_outpad[i]),
      .soc_dir    (gfpga_pad_io_soc_dir[i]),
      .soc_out    (gfpga_pad_io_soc_out[i]),
      .pin_inpad  (pin_inpad[i])
    );
  end

endmodule

// File: tb/tb_grid_io_bank_cfg.sv
// tb/tb_grid_io_bank_cfg.sv - scoreboard bench for grid_io_bank_cfg at NUM_IO 4, 1 and 16
module tb_grid_io_bank_cfg;

  localparam int NA = 4;
  localparam int NB = 1;
  localparam int NC = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        head;
  logic [2:0]  en;
  logic [2:0]  cm;
  logic        iso;
  logic [63:0] si;
  logic [63:0] op;

  logic          t0, t1, t2, v0, v1, v2, e0, e1, e2;
  logic [NA-1:0] dir0, out0, inp0;
  logic [NB-1:0] dir1, out1, inp1;
  logic [NC-1:0] dir2, out2, inp2;

  grid_io_bank_cfg #(.NUM_IO(NA)) u_dut_a (
    .prog_clk(clk), .prog_reset(rst), .ccff_head(head), .ccff_en(en[0]),
    .cfg_commit(cm[0]), .isol_n(iso), .gfpga_pad_io_soc_in(si[NA-1:0]),
    .pin_outpad(op[NA-1:0]), .ccff_tail(t0), .gfpga_pad_io_soc_dir(dir0),
    .gfpga_pad_io_soc_out(out0), .pin_inpad(inp0), .cfg_valid(v0), .cfg_err(e0));

  grid_io_bank_cfg #(.NUM_IO(NB)) u_dut_b (
    .prog_clk(clk), .prog_reset(rst), .ccff_head(head), .ccff_en(en[1]),
    .cfg_commit(cm[1]), .isol_n(iso), .gfpga_pad_io_soc_in(si[NB-1:0]),
    .pin_outpad(op[NB-1:0]), .ccff_tail(t1), .gfpga_pad_io_soc_dir(dir1),
    .gfpga_pad_io_soc_out(out1), .pin_inpad(inp1), .cfg_valid(v1), .cfg_err(e1));

  grid_io_bank_cfg #(.NUM_IO(NC)) u_dut_c (
    .prog_clk(clk), .prog_reset(rst), .ccff_head(head), .ccff_en(en[2]),
    .cfg_commit(cm[2]), .isol_n(iso), .gfpga_pad_io_soc_in(si[NC-1:0]),
    .pin_outpad(op[NC-1:0]), .ccff_tail(t2), .gfpga_pad_io_soc_dir(dir2),
    .gfpga_pad_io_soc_out(out2), .pin_inpad(inp2), .cfg_valid(v2), .cfg_err(e2));

  logic [63:0] a_dir [3];
  logic [63:0] a_out [3];
  logic [63:0] a_inp [3];
  logic        a_tail[3];
  logic        a_val [3];
  logic        a_err [3];

  assign a_dir[0] = 64'(dir0);  assign a_out[0] = 64'(out0);  assign a_inp[0] = 64'(inp0);
  assign a_dir[1] = 64'(dir1);  assign a_out[1] = 64'(out1);  assign a_inp[1] = 64'(inp1);
  assign a_dir[2] = 64'(dir2);  assign a_out[2] = 64'(out2);  assign a_inp[2] = 64'(inp2);
  assign a_tail[0] = t0;  assign a_tail[1] = t1;  assign a_tail[2] = t2;
  assign a_val[0]  = v0;  assign a_val[1]  = v1;  assign a_val[2]  = v2;
  assign a_err[0]  = e0;  assign a_err[1]  = e1;  assign a_err[2]  = e2;

  // Reference model: history of shifted bits (newest first), shifts since the
  // last commit attempt, and the per-channel live mode.
  bit          hist [3][$];
  int          cnt_m [3];
  logic [63:0] dir_m [3];
  logic [63:0] inv_m [3];
  bit          val_m [3];
  bit          err_m [3];
  bit          known = 1'b0;

  typedef struct {
    int          inst;
    logic        tail;
    logic [63:0] dir;
    logic [63:0] out;
    logic [63:0] inp;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic        nxt_iso;
  logic [63:0] nxt_si;
  logic [63:0] nxt_op;

  function automatic int nio(int i);
    case (i)
      0:       return NA;
      1:       return NB;
      default: return NC;
    endcase
  endfunction

  function automatic logic [63:0] mask(int n);
    if (n >= 64) return '1;
    return (64'd1 << n) - 64'd1;
  endfunction

  // Bit k of the chain is the bit shifted in k shifts ago, zero if none.
  function automatic logic cbit(int i, int k);
    if (k < hist[i].size()) return hist[i][k];
    return 1'b0;
  endfunction

  function automatic exp_t expect_of(int i);
    exp_t        e;
    logic [63:0] m;
    m       = mask(nio(i));
    e.inst  = i;
    e.tail  = cbit(i, 2 * nio(i) - 1);
    e.dir   = '0;
    e.out   = '0;
    e.inp   = '0;
    for (int ch = 0; ch < nio(i); ch++) begin
      if (!iso) begin
        e.dir[ch] = 1'b1;
      end else if (dir_m[i][ch]) begin
        e.dir[ch] = 1'b1;
        e.inp[ch] = si[ch] ^ inv_m[i][ch];
      end else begin
        e.out[ch] = op[ch] ^ inv_m[i][ch];
      end
    end
    e.dir   = e.dir & m;
    e.valid = val_m[i];
    e.err   = err_m[i];
    return e;
  endfunction

  task automatic model_edge(int i);
    int tot;
    tot = 2 * nio(i);
    if (rst) begin
      hist[i].delete();
      cnt_m[i] = 0;
      dir_m[i] = mask(nio(i));
      inv_m[i] = '0;
      val_m[i] = 1'b0;
      err_m[i] = 1'b0;
    end else begin
      if (cm[i]) begin
        if (cnt_m[i] == tot) begin
          for (int ch = 0; ch < nio(i); ch++) begin
            dir_m[i][ch] = cbit(i, 2 * ch);
            inv_m[i][ch] = cbit(i, 2 * ch + 1);
          end
          val_m[i] = 1'b1;
        end else if (cnt_m[i] > 0) begin
          err_m[i] = 1'b1;
        end
        cnt_m[i] = 0;
      end
      if (en[i]) begin
        hist[i].push_front(head);
        if (hist[i].size() > tot) void'(hist[i].pop_back());
        if (cnt_m[i] < tot) cnt_m[i]++;
      end
    end
  endtask

  // One clock cycle: drive inputs just after the edge, queue what the pads must
  // show during this cycle, then advance the model to the next edge.
  task automatic step(input logic r, input logic [2:0] e, input logic [2:0] c, input logic h);
    @(posedge clk);
    #1;
    rst  = r;
    en   = e;
    cm   = c;
    head = h;
    iso  = nxt_iso;
    si   = nxt_si;
    op   = nxt_op;
    if (known) begin
      for (int i = 0; i < 3; i++) sb.push_back(expect_of(i));
    end
    for (int i = 0; i < 3; i++) model_edge(i);
    if (r) known = 1'b1;
  endtask

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ccff_tail", e.inst, 64'(a_tail[e.inst]), 64'(e.tail));
        chk("soc_dir",   e.inst, a_dir[e.inst], e.dir);
        chk("soc_out",   e.inst, a_out[e.inst], e.out);
        chk("pin_inpad", e.inst, a_inp[e.inst], e.inp);
        chk("cfg_valid", e.inst, 64'(a_val[e.inst]), 64'(e.valid));
        chk("cfg_err",   e.inst, 64'(a_err[e.inst]), 64'(e.err));
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle(int k);
    for (int j = 0; j < k; j++) step(1'b0, 3'b000, 3'b000, 1'($urandom));
  endtask

  task automatic do_reset(int k);
    for (int j = 0; j < k; j++) step(1'b1, 3'b000, 3'b000, 1'b0);
  endtask

  // Shifts v[k-1] first so that v[0] ends up at chain position 0.
  task automatic shift_n(int s, int k, logic [127:0] v);
    for (int j = k - 1; j >= 0; j--) step(1'b0, 3'(1 << s), 3'b000, v[j]);
  endtask

  task automatic commit(int s);
    step(1'b0, 3'b000, 3'(1 << s), 1'($urandom));
  endtask

  task automatic directed(int s);
    int           tot;
    logic [127:0] v;
    tot = 2 * nio(s);
    nxt_iso = 1'b1;
    nxt_si  = {16{4'hA}};
    nxt_op  = '0;
    do_reset(2);
    idle(2);
    // Channel 0 output non-inverted, remaining channels input inverted.
    v = '1;
    v[1:0] = 2'b00;
    nxt_op = 64'd1;
    nxt_si = '0;
    shift_n(s, tot, v);
    idle(1);
    commit(s);
    idle(2);
    // Premature commit, then a complete load.
    shift_n(s, 5, rnd128());
    commit(s);
    idle(1);
    shift_n(s, tot, rnd128());
    commit(s);
    idle(1);
    // Pass-through: extra shifts, commit keeps the last tot bits.
    shift_n(s, tot + 4, rnd128());
    commit(s);
    nxt_si = {$urandom, $urandom};
    nxt_op = {$urandom, $urandom};
    idle(1);
    nxt_iso = 1'b0;
    idle(2);
    nxt_iso = 1'b1;
    idle(2);
    // Reset in the middle of a load, on a shift edge.
    shift_n(s, 6, rnd128());
    step(1'b1, 3'(1 << s), 3'(1 << s), 1'b1);
    idle(1);
    shift_n(s, tot, rnd128());
    commit(s);
    idle(1);
    // Commit together with a shift.
    shift_n(s, 3, rnd128());
    step(1'b0, 3'(1 << s), 3'(1 << s), 1'b1);
    shift_n(s, tot - 1, rnd128());
    commit(s);
    shift_n(s, tot, rnd128());
    step(1'b0, 3'(1 << s), 3'(1 << s), 1'b0);
    idle(2);
  endtask

  initial begin
    rst = 1'b1; head = 1'b0; en = '0; cm = '0; iso = 1'b1; si = '0; op = '0;
    nxt_iso = 1'b1; nxt_si = '0; nxt_op = '0;

    for (int s = 0; s < 3; s++) directed(s);

    for (int j = 0; j < 3000; j++) begin
      logic [2:0] c;
      for (int b = 0; b < 3; b++) c[b] = ($urandom_range(0, 39) == 0);
      nxt_iso = ($urandom_range(0, 9) != 0);
      nxt_si  = {$urandom, $urandom};
      nxt_op  = {$urandom, $urandom};
      step(($urandom_range(0, 399) == 0), 3'($urandom), c, 1'($urandom));
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 0, 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
